// File: rtl/dcache_ctrl.sv
// dcache_ctrl: sequencing controller for the 8-line x 4-word direct-mapped
// data cache. It resolves hits, runs line fills from the synchronous D-memory,
// and performs write-through with write-allocate. It also drives the
// pipeline stall handshake and keeps saturating hit/miss counters.
//
// Ports:
//   CLK, RST                  clock, asynchronous active-high reset
//   REQ_CSN/WEN/ADDR/BE/DI    pipeline request (held stable until RDY=1)
//   HIT                       tag match AND valid for REQ_ADDR (combinational)
//   MEM_CSN/WEN/ADDR/BE/DI    D-memory command, MEM_DOUT read data (1-cycle latency)
//   FILL_WE/WORD/DATA         data-array line-fill write port
//   TAG_WE                    tag/valid write at REQ_ADDR index
//   WR_WE                     data-array write of REQ_DI/REQ_BE on a write hit
//   RDY, VALID                stall / read-data-valid to the pipeline
//   HIT_CNT, MISS_CNT         saturating performance counters
module dcache_ctrl #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_CSN,
  input  logic              REQ_WEN,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [3:0]        REQ_BE,
  input  logic [31:0]       REQ_DI,
  input  logic              HIT,
  output logic              MEM_CSN,
  output logic              MEM_WEN,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [3:0]        MEM_BE,
  output logic [31:0]       MEM_DI,
  input  logic [31:0]       MEM_DOUT,
  output logic              FILL_WE,
  output logic [1:0]        FILL_WORD,
  output logic [31:0]       FILL_DATA,
  output logic              TAG_WE,
  output logic              WR_WE,
  output logic              RDY,
  output logic              VALID,
  output logic [CNT_W-1:0]  HIT_CNT,
  output logic [CNT_W-1:0]  MISS_CNT
);

  typedef enum logic [2:0] {IDLE, WT, FILL, FILL_END, RESP} state_t;

  state_t              state, state_nxt;
  logic [1:0]          cnt;
  logic                l_wen;
  logic                l_hit;
  logic [ADDR_W-1:0]   l_addr;
  logic [3:0]          l_be;
  logic [31:0]         l_di;
  logic                accept;

  assign accept = (state == IDLE) && !REQ_CSN;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      l_wen  <= 1'b0;
      l_hit  <= 1'b0;
      l_addr <= '0;
      l_be   <= '0;
      l_di   <= '0;
    end else begin
      state <= state_nxt;
      // cnt is zero on FILL entry and steps once per FILL cycle
      if (state == FILL) cnt <= cnt + 2'd1;
      else               cnt <= '0;
      if (accept) begin
        l_wen  <= REQ_WEN;
        l_hit  <= HIT;
        l_addr <= REQ_ADDR;
        l_be   <= REQ_BE;
        l_di   <= REQ_DI;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      HIT_CNT  <= '0;
      MISS_CNT <= '0;
    end else if (accept) begin
      if (HIT) begin
        if (HIT_CNT != '1) HIT_CNT <= HIT_CNT + 1'b1;
      end else begin
        if (MISS_CNT != '1) MISS_CNT <= MISS_CNT + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    MEM_CSN   = 1'b1;
    MEM_WEN   = 1'b0;
    MEM_ADDR  = '0;
    MEM_BE    = '0;
    MEM_DI    = '0;
    FILL_WE   = 1'b0;
    FILL_WORD = '0;
    TAG_WE    = 1'b0;
    WR_WE     = 1'b0;
    RDY       = 1'b0;
    VALID     = 1'b0;
    case (state)
      IDLE: begin
        RDY = 1'b1;
        if (!REQ_CSN) begin
          if (REQ_WEN) begin
            RDY       = 1'b0;
            state_nxt = WT;
          end else if (HIT) begin
            VALID = 1'b1;
          end else begin
            RDY       = 1'b0;
            state_nxt = FILL;
          end
        end
      end
      WT: begin
        MEM_CSN  = 1'b0;
        MEM_WEN  = 1'b1;
        MEM_ADDR = l_addr;
        MEM_BE   = l_be;
        MEM_DI   = l_di;
        if (l_hit) begin
          WR_WE     = 1'b1;
          RDY       = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        MEM_CSN  = 1'b0;
        MEM_BE   = 4'b1111;
        MEM_ADDR = {l_addr[ADDR_W-1:2], cnt};
        // memory data lags the address by one cycle, so word cnt-1 lands now
        if (cnt != 2'd0) begin
          FILL_WE   = 1'b1;
          FILL_WORD = cnt - 2'd1;
        end
        if (cnt == 2'd3) state_nxt = FILL_END;
      end
      FILL_END: begin
        FILL_WE   = 1'b1;
        FILL_WORD = 2'd3;
        TAG_WE    = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        RDY       = 1'b1;
        VALID     = !l_wen;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign FILL_DATA = FILL_WE ? MEM_DOUT : '0;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with behavioural D-memory, tag array and
// data array around it, plus a scoreboard of expected request results.
module tb_dcache_ctrl;

  localparam int unsigned CW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          REQ_CSN, REQ_WEN;
  logic [11:0]   REQ_ADDR;
  logic [3:0]    REQ_BE;
  logic [31:0]   REQ_DI;
  logic          HIT;
  logic          MEM_CSN, MEM_WEN;
  logic [11:0]   MEM_ADDR;
  logic [3:0]    MEM_BE;
  logic [31:0]   MEM_DI;
  logic [31:0]   MEM_DOUT;
  logic          FILL_WE;
  logic [1:0]    FILL_WORD;
  logic [31:0]   FILL_DATA;
  logic          TAG_WE, WR_WE, RDY, VALID;
  logic [CW-1:0] HIT_CNT, MISS_CNT;

  dcache_ctrl #(.CNT_W(CW), .ADDR_W(12)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_CSN(REQ_CSN), .REQ_WEN(REQ_WEN), .REQ_ADDR(REQ_ADDR),
    .REQ_BE(REQ_BE), .REQ_DI(REQ_DI), .HIT(HIT),
    .MEM_CSN(MEM_CSN), .MEM_WEN(MEM_WEN), .MEM_ADDR(MEM_ADDR),
    .MEM_BE(MEM_BE), .MEM_DI(MEM_DI), .MEM_DOUT(MEM_DOUT),
    .FILL_WE(FILL_WE), .FILL_WORD(FILL_WORD), .FILL_DATA(FILL_DATA),
    .TAG_WE(TAG_WE), .WR_WE(WR_WE), .RDY(RDY), .VALID(VALID),
    .HIT_CNT(HIT_CNT), .MISS_CNT(MISS_CNT)
  );

  always #5 CLK = ~CLK;

  // environment: D-memory, tag/valid array, data array
  logic [31:0] dmem [0:4095];
  logic [31:0] gold [0:4095];
  logic [31:0] darr [0:31];
  logic [6:0]  tg   [0:7];
  logic        tv   [0:7];

  assign HIT = tv[REQ_ADDR[4:2]] && (tg[REQ_ADDR[4:2]] == REQ_ADDR[11:5]);

  always @(posedge CLK) begin
    if (!MEM_CSN) begin
      if (MEM_WEN) begin
        for (int b = 0; b < 4; b++)
          if (MEM_BE[b]) dmem[MEM_ADDR][8*b +: 8] <= MEM_DI[8*b +: 8];
      end else begin
        MEM_DOUT <= dmem[MEM_ADDR];
      end
    end
    if (FILL_WE) darr[{REQ_ADDR[4:2], FILL_WORD}] <= FILL_DATA;
    if (WR_WE)
      for (int b = 0; b < 4; b++)
        if (REQ_BE[b]) darr[REQ_ADDR[4:0]][8*b +: 8] <= REQ_DI[8*b +: 8];
    if (TAG_WE) begin
      tv[REQ_ADDR[4:2]] <= 1'b1;
      tg[REQ_ADDR[4:2]] <= REQ_ADDR[11:5];
    end
  end

  typedef struct {
    logic        rdy, valid, mcsn, mwen;
    logic [11:0] maddr;
    logic [3:0]  mbe;
    logic [31:0] mdi;
    logic        fwe;
    logic [1:0]  fword;
    logic        twe, wwe;
  } smp_t;

  typedef struct {
    logic        wen;
    logic [11:0] addr;
    logic [31:0] data;
  } sb_t;

  smp_t        tr [0:19];
  sb_t         sbq [$];
  int unsigned ncyc;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one request, records per-cycle outputs into tr[0..ncyc] (ncyc =
  // cycle of RDY=1 counted from acceptance), then checks the scoreboard.
  task automatic run_req(input logic wen, input logic [11:0] addr,
                         input logic [3:0] be, input logic [31:0] di);
    sb_t  e, got;
    logic done;
    logic [31:0] m;
    REQ_CSN = 1'b0; REQ_WEN = wen; REQ_ADDR = addr; REQ_BE = be; REQ_DI = di;
    m = gold[addr];
    if (wen)
      for (int b = 0; b < 4; b++)
        if (be[b]) m[8*b +: 8] = di[8*b +: 8];
    gold[addr] = m;
    e.wen = wen; e.addr = addr; e.data = m;
    sbq.push_back(e);
    done = 1'b0;
    ncyc = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge CLK);
      tr[t].rdy = RDY;    tr[t].valid = VALID; tr[t].mcsn = MEM_CSN;
      tr[t].mwen = MEM_WEN; tr[t].maddr = MEM_ADDR; tr[t].mbe = MEM_BE;
      tr[t].mdi = MEM_DI; tr[t].fwe = FILL_WE; tr[t].fword = FILL_WORD;
      tr[t].twe = TAG_WE; tr[t].wwe = WR_WE;
      if (RDY) begin
        ncyc = t;
        done = 1'b1;
        break;
      end
      @(posedge CLK); #1;
    end
    if (!done) chk("rdy_timeout", 32'(done), 32'd1);
    @(posedge CLK); #1;
    REQ_CSN = 1'b1;
    got = sbq.pop_front();
    if (got.wen) chk($sformatf("sb_mem_%h", got.addr), dmem[got.addr], got.data);
    else         chk($sformatf("sb_arr_%h", got.addr), darr[got.addr[4:0]], got.data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    for (int i = 0; i < 4096; i++) begin
      dmem[i] = 32'hA500_0000 | 32'(i);
      gold[i] = 32'hA500_0000 | 32'(i);
    end
    for (int i = 0; i < 32; i++) darr[i] = '0;
    for (int i = 0; i < 8; i++) begin tv[i] = 1'b0; tg[i] = '0; end
    MEM_DOUT = '0;
    REQ_CSN = 1'b1; REQ_WEN = 1'b0; REQ_ADDR = '0; REQ_BE = '0; REQ_DI = '0;

    // 1: reset
    RST = 1'b1;
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_rdy", 32'(RDY), 32'd1);
    chk("rst_valid", 32'(VALID), 32'd0);
    chk("rst_mcsn", 32'(MEM_CSN), 32'd1);
    chk("rst_we", {29'd0, FILL_WE, TAG_WE, WR_WE}, 32'd0);
    chk("rst_hcnt", 32'(HIT_CNT), 32'd0);
    chk("rst_mcnt", 32'(MISS_CNT), 32'd0);
    @(posedge CLK); #1;

    // 2: read miss at 0x025
    run_req(1'b0, 12'h025, 4'h0, 32'h0);
    chk("rm_lat", ncyc, 32'd6);
    chk("rm_t0_rdy", 32'(tr[0].rdy), 32'd0);
    for (int t = 1; t <= 4; t++) begin
      chk($sformatf("rm_maddr_t%0d", t), 32'(tr[t].maddr), 32'h024 + 32'(t - 1));
      chk($sformatf("rm_mcmd_t%0d", t), {tr[t].mcsn, tr[t].mwen, tr[t].mbe}, 32'h0F);
    end
    for (int t = 2; t <= 5; t++)
      chk($sformatf("rm_fill_t%0d", t), {tr[t].fwe, tr[t].fword}, 32'h4 | 32'(t - 2));
    n = 0;
    for (int t = 0; t <= 6; t++) n += 32'(tr[t].twe);
    chk("rm_tagwe_cnt", n, 32'd1);
    chk("rm_tagwe_t5", 32'(tr[5].twe), 32'd1);
    chk("rm_t6", {tr[6].rdy, tr[6].valid, tr[6].mcsn}, 32'h7);
    chk("rm_mcnt", 32'(MISS_CNT), 32'd1);

    // 3: read hit right after
    run_req(1'b0, 12'h026, 4'h0, 32'h0);
    chk("rh_lat", ncyc, 32'd0);
    chk("rh_t0", {tr[0].valid, tr[0].mcsn}, 32'h3);
    chk("rh_hcnt", 32'(HIT_CNT), 32'd1);

    // 4: write hit at 0x024
    run_req(1'b1, 12'h024, 4'hF, 32'hDEAD_BEEF);
    chk("wh_lat", ncyc, 32'd1);
    chk("wh_t0_rdy", 32'(tr[0].rdy), 32'd0);
    chk("wh_t1_cmd", {tr[1].mcsn, tr[1].mwen, tr[1].wwe, tr[1].rdy}, 32'h7);
    chk("wh_t1_addr", 32'(tr[1].maddr), 32'h024);
    chk("wh_t1_di", tr[1].mdi, 32'hDEAD_BEEF);
    run_req(1'b0, 12'h024, 4'h0, 32'h0);
    chk("wh_rd_lat", ncyc, 32'd0);

    // 5: write miss at 0x100, partial byte enables
    run_req(1'b1, 12'h100, 4'b0011, 32'h1234_5678);
    chk("wm_lat", ncyc, 32'd7);
    chk("wm_t1_cmd", {tr[1].mcsn, tr[1].mwen, tr[1].mbe}, 32'h13);
    for (int t = 2; t <= 5; t++)
      chk($sformatf("wm_maddr_t%0d", t), {tr[t].mwen, tr[t].maddr}, 32'h100 + 32'(t - 2));
    chk("wm_tagwe_t6", 32'(tr[6].twe), 32'd1);
    chk("wm_t7", {tr[7].rdy, tr[7].valid}, 32'h2);
    n = 0;
    for (int t = 0; t <= 7; t++) n += 32'(tr[t].wwe);
    chk("wm_wrwe_cnt", n, 32'd0);
    chk("wm_mcnt", 32'(MISS_CNT), 32'd2);
    run_req(1'b0, 12'h100, 4'h0, 32'h0);
    chk("wm_rd_lat", ncyc, 32'd0);
    run_req(1'b0, 12'h101, 4'h0, 32'h0);
    chk("hcnt_5", 32'(HIT_CNT), 32'd5);

    // counter saturation
    for (int i = 0; i < 12; i++) run_req(1'b0, 12'h027, 4'h0, 32'h0);
    chk("hcnt_sat", 32'(HIT_CNT), 32'hF);

    // 6: reset while cnt=2 in a fill
    REQ_CSN = 1'b0; REQ_WEN = 1'b0; REQ_ADDR = 12'h200; REQ_BE = '0; REQ_DI = '0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("ab_maddr", 32'(MEM_ADDR), 32'h202);
    chk("ab_tagwe_pre", 32'(TAG_WE), 32'd0);
    RST = 1'b1;
    #1;
    chk("ab_async", {MEM_CSN, FILL_WE, TAG_WE}, 32'h4);
    REQ_CSN = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("ab_rdy", 32'(RDY), 32'd1);
    chk("ab_valid_idx0", {31'd0, tv[0] && tg[0] == 7'h10}, 32'd0);
    @(posedge CLK); #1;
    run_req(1'b0, 12'h200, 4'h0, 32'h0);
    chk("ab_rd_lat", ncyc, 32'd6);
    chk("ab_mcnt", 32'(MISS_CNT), 32'd1);
    chk("ab_hcnt", 32'(HIT_CNT), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
